// File: rtl/row_window_buffer_pkg.sv
// Shared types and constants for the row window buffer.
// Holds the FSM state encoding, default geometry and the output-size helper.
package row_window_buffer_pkg;

  localparam int DEF_BIT_WIDTH = 16;
  localparam int DEF_IM_SIZE   = 28;
  localparam int DEF_K         = 5;

  // Width of the row/column window indices (enough for 0..27).
  localparam int IDX_W = 5;

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    SLIDE    = 2'd1,
    WAIT_ROW = 2'd2
  } state_e;

  // Number of valid-region windows along one image axis.
  function automatic int calc_out_size(input int im_size, input int k);
    return im_size - k + 1;
  endfunction

endpackage

// File: rtl/row_window_buffer_if.sv
// Row-in / window-out bus of the row window buffer.
// The master side feeds rows and consumes windows; the slave side is the buffer.
interface row_window_buffer_if
  import row_window_buffer_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int IM_SIZE   = DEF_IM_SIZE,
  parameter int K         = DEF_K
) ();

  logic [IM_SIZE*BIT_WIDTH-1:0] row_in;
  logic                         row_valid;
  logic                         row_ready;
  logic [K*K*BIT_WIDTH-1:0]     win_out;
  logic                         win_valid;
  logic                         win_ready;
  logic [IDX_W-1:0]             win_row;
  logic [IDX_W-1:0]             win_col;
  logic                         frame_done;
  logic                         overflow;

  modport master (
    output row_in, row_valid, win_ready,
    input  row_ready, win_out, win_valid, win_row, win_col, frame_done, overflow
  );

  modport slave (
    input  row_in, row_valid, win_ready,
    output row_ready, win_out, win_valid, win_row, win_col, frame_done, overflow
  );

endinterface

// File: rtl/row_window_buffer_line_buffer.sv
// K x IM_SIZE line buffer holding the most recent K image rows.
// Row r=0 is the oldest; a shift drops it and the new row lands in r=K-1.
// The window select looks through a pending shift so the caller can
// register a window built from the row being captured in the same cycle.
module line_buffer_k
  import row_window_buffer_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int IM_SIZE   = DEF_IM_SIZE,
  parameter int K         = DEF_K
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         shift_en_i,
  input  logic [IM_SIZE*BIT_WIDTH-1:0] row_i,
  input  logic [IDX_W-1:0]             sel_col_i,
  output logic [K*K*BIT_WIDTH-1:0]     win_o
);

  localparam int CW = $clog2(IM_SIZE);

  logic [BIT_WIDTH-1:0] lines_q [K][IM_SIZE];
  logic [BIT_WIDTH-1:0] lines_d [K][IM_SIZE];

  // Post-shift contents: older rows move up, the incoming row is unpacked
  // so that flattened element IM_SIZE-1 becomes column 0.
  always_comb begin
    lines_d = lines_q;
    for (int r = 0; r < K - 1; r++) begin
      lines_d[r] = lines_q[r + 1];
    end
    for (int c = 0; c < IM_SIZE; c++) begin
      lines_d[K-1][c] = row_i[(IM_SIZE-1-c)*BIT_WIDTH +: BIT_WIDTH];
    end
  end

  // Line storage, updated only when a row is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lines_q <= '{default: '0};
    end else if (shift_en_i) begin
      lines_q <= lines_d;
    end
  end

  // K x K window starting at column sel_col_i, entry (r,c) at r*K+c.
  always_comb begin
    int               col;
    logic [CW-1:0]    col_idx;
    win_o   = '0;
    col     = 0;
    col_idx = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        col     = int'(sel_col_i) + c;
        col_idx = CW'(col);
        if (col < IM_SIZE) begin
          win_o[(r*K+c)*BIT_WIDTH +: BIT_WIDTH] =
            shift_en_i ? lines_d[r][col_idx] : lines_q[r][col_idx];
        end
      end
    end
  end

endmodule

// File: rtl/row_window_buffer.sv
// Row window buffer: captures full image rows and streams every KxK
// valid-region window in raster order over a valid/ready handshake.
// Optional build macro ROW_WINDOW_DROP_CNT_EN adds an 8-bit saturating
// count of rows rejected while the buffer was busy (drop_cnt).
module row_window_buffer
  import row_window_buffer_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int IM_SIZE   = DEF_IM_SIZE,
  parameter int K         = DEF_K
) (
  input logic                clk,
  input logic                rst,
  row_window_buffer_if.slave win_if
`ifdef ROW_WINDOW_DROP_CNT_EN
  ,
  output logic [7:0]         drop_cnt
`endif
);

  localparam int OUT_SIZE = calc_out_size(IM_SIZE, K);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_SIZE - 1);
  localparam logic [IDX_W-1:0] K_LAST   = IDX_W'(K - 1);

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         rows_in_q, rows_in_d;
  logic [IDX_W-1:0]         out_row_q, out_row_d;
  logic [IDX_W-1:0]         out_col_q, out_col_d;
  logic [K*K*BIT_WIDTH-1:0] win_out_q, win_out_d;
  logic                     win_valid_q, win_valid_d;
  logic                     frame_done_q, frame_done_d;
  logic                     overflow_q, overflow_d;
  logic [K*K*BIT_WIDTH-1:0] lb_win;
  logic [IDX_W-1:0]         sel_col;
  logic                     shift_en;
  logic                     row_ready;
  logic                     row_accept;
  logic                     row_reject;
  logic                     win_fire;

  assign row_ready  = (state_q != SLIDE);
  assign row_accept = win_if.row_valid & row_ready;
  assign row_reject = win_if.row_valid & ~row_ready;
  assign win_fire   = win_valid_q & win_if.win_ready;

  line_buffer_k #(
    .BIT_WIDTH (BIT_WIDTH),
    .IM_SIZE   (IM_SIZE),
    .K         (K)
  ) u_lines (
    .clk        (clk),
    .rst        (rst),
    .shift_en_i (shift_en),
    .row_i      (win_if.row_in),
    .sel_col_i  (sel_col),
    .win_o      (lb_win)
  );

  // Next-state logic: fill K rows, slide across the row, wait for the next row.
  always_comb begin
    state_d      = state_q;
    rows_in_d    = rows_in_q;
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
    win_out_d    = win_out_q;
    win_valid_d  = win_valid_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q | row_reject;
    shift_en     = 1'b0;
    sel_col      = '0;
    case (state_q)
      FILL: begin
        if (row_accept) begin
          shift_en  = 1'b1;
          rows_in_d = rows_in_q + 1'b1;
          if (rows_in_q == K_LAST) begin
            state_d     = SLIDE;
            out_col_d   = '0;
            win_out_d   = lb_win;
            win_valid_d = 1'b1;
          end
        end
      end
      WAIT_ROW: begin
        if (row_accept) begin
          shift_en    = 1'b1;
          state_d     = SLIDE;
          out_col_d   = '0;
          win_out_d   = lb_win;
          win_valid_d = 1'b1;
        end
      end
      SLIDE: begin
        if (win_fire) begin
          if (out_col_q != LAST_IDX) begin
            out_col_d = out_col_q + 1'b1;
            sel_col   = out_col_q + 1'b1;
            win_out_d = lb_win;
          end else if (out_row_q != LAST_IDX) begin
            win_valid_d = 1'b0;
            out_row_d   = out_row_q + 1'b1;
            state_d     = WAIT_ROW;
          end else begin
            win_valid_d  = 1'b0;
            frame_done_d = 1'b1;
            state_d      = FILL;
            rows_in_d    = '0;
            out_row_d    = '0;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State, counters and the registered window output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= FILL;
      rows_in_q    <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      win_out_q    <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rows_in_q    <= rows_in_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      win_out_q    <= win_out_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

`ifdef ROW_WINDOW_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  // Saturating count of rows offered while the buffer was busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_q <= '0;
    end else if (row_reject && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign win_if.row_ready  = row_ready;
  assign win_if.win_out    = win_out_q;
  assign win_if.win_valid  = win_valid_q;
  assign win_if.win_row    = out_row_q;
  assign win_if.win_col    = out_col_q;
  assign win_if.frame_done = frame_done_q;
  assign win_if.overflow   = overflow_q;

endmodule

// File: doc/row_window_buffer.md
Name: row_window_buffer

Overview:
- Sits directly downstream of the ROM-to-row shift stage. Captures each completed 28-pixel image row when that stage pulses its full-row flag.
- Keeps the last K rows in a row-line buffer.
- Emits every KxK convolution window (valid-region, stride 1) in raster order to the conv array through a valid/ready handshake.
- Also reports frame completion.

Parameters:
- BIT_WIDTH, 16, pixel width in bits.
- IM_SIZE, 28, image width and height in pixels.
- K, 5, window edge; legal range 2..IM_SIZE.
- OUT_SIZE, IM_SIZE-K+1, windows per row and per column; derived, do not override.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- row_in  in  IM_SIZE*BIT_WIDTH  flattened row; element j is bits [j*BIT_WIDTH +: BIT_WIDTH]. Element IM_SIZE-1 is column 0 (oldest shifted pixel); element 0 is column IM_SIZE-1.
- row_valid  in  1  full-row flag from the upstream stage; a row is captured on any cycle with row_valid=1 and row_ready=1.
- row_ready  out  1  buffer can accept a row.
- win_out  out  K*K*BIT_WIDTH  window; entry (r,c) at index r*K+c. r=0 is the oldest (top) row, c=0 is the leftmost column.
- win_valid  out  1  win_out holds a valid window.
- win_ready  in  1  consumer accepts the window.
- win_row  out  5  output row index 0..OUT_SIZE-1.
- win_col  out  5  output column index 0..OUT_SIZE-1.
- frame_done  out  1  one-cycle pulse after the last window of a frame is accepted.
- overflow  out  1  sticky; set when row_valid=1 while row_ready=0.

Behaviour:
- Reset (rst=0, async):
  - State returns to FILL.
  - All counters, line-buffer contents, win_out, win_valid, frame_done and overflow clear to 0.
  - row_ready resets to 1.
  - Reset mid-frame discards all partial data.
- FILL:
  - row_ready=1.
  - Each accepted row is shifted into the line buffer; the oldest row is dropped and the new row becomes r=K-1.
  - rows_in increments on each accepted row.
  - When rows_in reaches K, the next state is SLIDE with out_col=0.
- SLIDE:
  - row_ready=0.
  - win_out is registered from the line buffer at columns out_col..out_col+K-1.
  - win_valid is 1 from the first cycle in SLIDE, i.e. one cycle after the K-th row capture edge.
  - win_out, win_row and win_col are held stable while win_valid=1 and win_ready=0.
  - On win_valid&&win_ready:
    - If out_col<OUT_SIZE-1: out_col increments and the next window is presented on the next cycle, giving 1 window/cycle throughput.
    - If out_col=OUT_SIZE-1 and out_row<OUT_SIZE-1: win_valid drops to 0, out_row increments, and the state goes to WAIT_ROW.
    - If out_col=OUT_SIZE-1 and out_row=OUT_SIZE-1: win_valid drops to 0, frame_done pulses for one cycle, and the state goes to FILL with rows_in=0 and out_row=0.
- WAIT_ROW:
  - row_ready=1.
  - An accepted row is shifted in; the next state is SLIDE with out_col=0.
- Row index: win_row=out_row, win_col=out_col. All indices are unsigned and never wrap past OUT_SIZE-1.
- Simultaneous row_valid and a window handshake in SLIDE: the row is not captured (row_ready=0) and overflow is set; the window handshake proceeds normally.
- overflow clears only on reset.
- Rows of the next frame arriving in FILL after frame_done are accepted normally; the line buffer is not cleared between frames, and rows_in gates output.
- Data is passed through unmodified; no arithmetic on pixel values.

Optional Feature:
- Macro: ROW_WINDOW_DROP_CNT_EN.
- Defined: adds output port drop_cnt [7:0], an 8-bit saturating count of rejected rows (row_valid=1 and row_ready=0). It saturates at 255, clears on reset, and increments in the same cycle that overflow sets or remains set.
- Undefined: the port and the counter do not exist; overflow behaviour is unchanged.

Decomposition:
- Shared package: state enum {FILL, SLIDE, WAIT_ROW}; derived OUT_SIZE; helper constant for index width (5 bits for IM_SIZE=28); default BIT_WIDTH/IM_SIZE/K constants.
- Sub-module line_buffer_k: K x IM_SIZE register array with shift-in-row enable and a combinational K-column window select by out_col.
- row_window_buffer holds the FSM, counters, output register and handshake.

Test Plan:
- Reset: rst=0 mid-SLIDE → win_valid=0, row_ready=1, overflow=0, frame_done=0 within the same cycle; after release, 5 rows are needed before the first window.
- Fill plus first window: feed rows where pixel value = row*100+col (K=5), win_ready=1 → the cycle after the 5th row, win_valid=1, win_row=0, win_col=0, win_out[0]=0, win_out[24]=404; the next cycle gives win_col=1, win_out[0]=1.
- Backpressure: hold win_ready=0 for 10 cycles at win_col=3 → win_out, win_col and win_valid are stable. Release → win_col=4 on the next cycle.
- Row boundary: accept win_col=23 → win_valid=0, row_ready=1. Feed row 5 → the first window has win_row=1, win_col=0, win_out[0]=100.
- Overflow: pulse row_valid during SLIDE → overflow=1 and stays 1, and the row is not captured (the next windows still carry the old rows). With ROW_WINDOW_DROP_CNT_EN, 300 drops → drop_cnt=255.
- Full frame: 28 rows with win_ready=1 → exactly 576 windows, frame_done pulses once after win_row=23, win_col=23. The next frame restarts at win_row=0.
